// File: rtl/sram_bist_master.sv
// sram_bist_master
// Avalon-MM master that self-tests a single-port, word-addressed SRAM. It
// writes an address-derived pattern (seed ^ address) over a word range, reads
// the range back and counts words whose read data differs from the pattern.
//
// Ports
//   clk, reset_n          clock, asynchronous active-low reset
//   start                 one-cycle request; ignored unless idle
//   base_addr, word_count range to test (word_count 0..2^ADDR_W), sampled on start
//   seed                  pattern seed, sampled on start
//   busy, done            test in progress / one-cycle completion pulse
//   err_count             saturating mismatch count
//   first_err_addr        address of the first mismatching word (0 if none)
//   address, byteenable, chipselect, write, writedata, clken  SRAM master side
//   readdata              SRAM read data, valid READ_LATENCY cycles after issue
module sram_bist_master #(
  parameter int ADDR_W       = 14,
  parameter int DATA_W       = 32,
  parameter int READ_LATENCY = 1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic [ADDR_W-1:0]   base_addr,
  input  logic [ADDR_W:0]     word_count,
  input  logic [DATA_W-1:0]   seed,
  output logic                busy,
  output logic                done,
  output logic [15:0]         err_count,
  output logic [ADDR_W-1:0]   first_err_addr,
  output logic [ADDR_W-1:0]   address,
  output logic [DATA_W/8-1:0] byteenable,
  output logic                chipselect,
  output logic                write,
  output logic [DATA_W-1:0]   writedata,
  output logic                clken,
  input  logic [DATA_W-1:0]   readdata
);

  localparam int BE_W  = DATA_W / 8;
  localparam int DRN_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
  localparam logic [DRN_W-1:0] DRN_LAST = DRN_W'(READ_LATENCY - 1);
  localparam logic [15:0] ERR_MAX = 16'hFFFF;

  typedef enum logic [2:0] {S_IDLE, S_WRITE, S_READ, S_DRAIN, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;      // index of the access currently on the bus
  logic [ADDR_W-1:0]   last_q, last_d;    // N-1
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [DATA_W-1:0]   seed_q, seed_d;
  logic [DRN_W-1:0]    drain_q, drain_d;
  logic [15:0]         err_q, err_d;
  logic [ADDR_W-1:0]   ferr_q, ferr_d;
  logic                cs_q, cs_d;
  logic                wr_q, wr_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                clken_q;

  // Compare pipeline: one stage per cycle of read latency, so the last stage
  // lines up with the readdata belonging to the same read.
  logic                pv_q [READ_LATENCY];
  logic [ADDR_W-1:0]   pa_q [READ_LATENCY];
  logic [DATA_W-1:0]   pe_q [READ_LATENCY];
  logic                pv_in [READ_LATENCY];
  logic [ADDR_W-1:0]   pa_in [READ_LATENCY];
  logic [DATA_W-1:0]   pe_in [READ_LATENCY];

  genvar gi;
  generate
    for (gi = 0; gi < READ_LATENCY; gi++) begin : g_pipe
      if (gi == 0) begin : g_head
        // A read is pushed in the cycle it is presented on the bus.
        assign pv_in[gi] = cs_q & ~wr_q;
        assign pa_in[gi] = addr_q;
        assign pe_in[gi] = seed_q ^ DATA_W'(addr_q);
      end else begin : g_tail
        assign pv_in[gi] = pv_q[gi-1];
        assign pa_in[gi] = pa_q[gi-1];
        assign pe_in[gi] = pe_q[gi-1];
      end
    end
  endgenerate

  logic              cmp_miss;
  logic [ADDR_W-1:0] step_addr;

  assign cmp_miss  = pv_q[READ_LATENCY-1] && (readdata != pe_q[READ_LATENCY-1]);
  assign step_addr = base_q + idx_q + ADDR_W'(1);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    last_d  = last_q;
    base_d  = base_q;
    seed_d  = seed_q;
    drain_d = drain_q;
    err_d   = err_q;
    ferr_d  = ferr_q;
    cs_d    = 1'b0;
    wr_d    = 1'b0;
    addr_d  = '0;
    wdata_d = '0;

    if (cmp_miss) begin
      if (err_q != ERR_MAX) err_d = err_q + 16'd1;
      if (err_q == 16'd0)   ferr_d = pa_q[READ_LATENCY-1];
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          err_d  = '0;
          ferr_d = '0;
          if (word_count == '0) begin
            state_d = S_DONE;
          end else begin
            base_d  = base_addr;
            seed_d  = seed;
            // For word_count = 2^ADDR_W the low bits are 0 and wrap to all ones.
            last_d  = word_count[ADDR_W-1:0] - ADDR_W'(1);
            idx_d   = '0;
            state_d = S_WRITE;
            cs_d    = 1'b1;
            wr_d    = 1'b1;
            addr_d  = base_addr;
            wdata_d = seed ^ DATA_W'(base_addr);
          end
        end
      end
      S_WRITE: begin
        cs_d = 1'b1;
        if (idx_q == last_q) begin
          idx_d   = '0;
          state_d = S_READ;
          addr_d  = base_q;
        end else begin
          idx_d   = idx_q + ADDR_W'(1);
          wr_d    = 1'b1;
          addr_d  = step_addr;
          wdata_d = seed_q ^ DATA_W'(step_addr);
        end
      end
      S_READ: begin
        if (idx_q == last_q) begin
          state_d = S_DRAIN;
          drain_d = '0;
        end else begin
          idx_d  = idx_q + ADDR_W'(1);
          cs_d   = 1'b1;
          addr_d = step_addr;
        end
      end
      S_DRAIN: begin
        if (drain_q == DRN_LAST) state_d = S_DONE;
        else                     drain_d = drain_q + DRN_W'(1);
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      last_q  <= '0;
      base_q  <= '0;
      seed_q  <= '0;
      drain_q <= '0;
      err_q   <= '0;
      ferr_q  <= '0;
      cs_q    <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      clken_q <= 1'b1;
      for (int k = 0; k < READ_LATENCY; k++) begin
        pv_q[k] <= 1'b0;
        pa_q[k] <= '0;
        pe_q[k] <= '0;
      end
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      base_q  <= base_d;
      seed_q  <= seed_d;
      drain_q <= drain_d;
      err_q   <= err_d;
      ferr_q  <= ferr_d;
      cs_q    <= cs_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      clken_q <= 1'b1;
      for (int k = 0; k < READ_LATENCY; k++) begin
        pv_q[k] <= pv_in[k];
        pa_q[k] <= pa_in[k];
        pe_q[k] <= pe_in[k];
      end
    end
  end

  assign busy           = (state_q == S_WRITE) || (state_q == S_READ) || (state_q == S_DRAIN);
  assign done           = (state_q == S_DONE);
  assign err_count      = err_q;
  assign first_err_addr = ferr_q;
  assign address        = addr_q;
  assign byteenable     = {BE_W{cs_q}};
  assign chipselect     = cs_q;
  assign write          = wr_q;
  assign writedata      = wdata_q;
  assign clken          = clken_q;

endmodule

// File: doc/sram_bist_master.md
# sram_bist_master

Avalon-MM master engine that drives the on-chip SRAM slave port from the other side: it fills a programmable word range with an address-derived pattern, reads the range back, and compares every returned word. It sits between a control register block (start/status) and the SRAM's single word-addressed port. Its purposes are power-on memory self-test and bring-up diagnostics.

## Interface
Parameters:
- ADDR_W, 14, word address width of the SRAM port.
- DATA_W, 32, data width. Byteenable width is DATA_W/8.
- READ_LATENCY, 1, cycles from read issue to readdata valid (address registered, output unregistered). Legal range 1..4.

Ports:
- clk  in  1  single clock for all logic.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request to begin a test. Ignored while busy.
- base_addr  in  ADDR_W  first word address, sampled on start.
- word_count  in  ADDR_W+1  number of words to test, sampled on start. Range 0..2^ADDR_W.
- seed  in  DATA_W  pattern seed, sampled on start.
- busy  out  1  high while the test is in progress.
- done  out  1  one-cycle pulse when the test completes.
- err_count  out  16  count of mismatching words. Saturates at 16'hFFFF.
- first_err_addr  out  ADDR_W  address of the first mismatch. Holds 0 when there are no errors.
- address  out  ADDR_W  SRAM word address.
- byteenable  out  DATA_W/8  always all-ones during an access, 0 when idle.
- chipselect  out  1  access strobe.
- write  out  1  write strobe. Qualified by chipselect.
- writedata  out  DATA_W  write data.
- clken  out  1  SRAM clock enable. Held at 1 after reset.
- readdata  in  DATA_W  SRAM read data.

## Operation
- FSM states: IDLE, WRITE, READ, DRAIN, DONE.
- IDLE: on start with word_count=0, go to DONE and clear err_count and first_err_addr. On start with word_count>0, latch the inputs, clear the error state, set index i=0, and go to WRITE.
- WRITE: each cycle issue one write: chipselect=1, write=1, address=(base_addr+i) mod 2^ADDR_W, writedata=seed ^ zero-extended address. After i=N-1, reset i to 0 and go to READ.
- READ: each cycle issue one read: chipselect=1, write=0, with the same address sequence. After the last read is issued, go to DRAIN.
- Expected data and address travel down a READ_LATENCY-deep shift pipeline with a valid bit. The engine compares readdata with the expected value when the pipeline output is valid.
- On a mismatch: increment err_count (saturating). If this is the first error, capture the address into first_err_addr.
- DRAIN: wait READ_LATENCY cycles for the outstanding compares, then go to DONE.
- DONE: pulse done for one cycle, then return to IDLE. err_count and first_err_addr hold their values until the next accepted start.
- Address arithmetic is modulo 2^ADDR_W, so the range wraps past the top of memory to 0.
- The caller keeps the range within the populated SRAM depth.

## Timing
- Reset values: busy=0, done=0, err_count=0, first_err_addr=0, address=0, byteenable=0, chipselect=0, write=0, writedata=0, clken=1. FSM goes to IDLE and the pipeline valid bits are cleared.
- Reset mid-test aborts immediately. No further bus accesses occur and no done pulse is generated.
- Let start be sampled at cycle 0, with N>0 and L=READ_LATENCY.
- Writes occur in cycles 1..N.
- Reads are issued in cycles N+1..2N.
- Compares occur in cycles N+1+L..2N+L.
- done is high in cycle 2N+L+1.
- busy is high in cycles 1..2N+L.
- With N=0: done is high in cycle 1 and busy never rises.
- Bus outputs are registered. chipselect, write and byteenable are 0 in every cycle without an access.
- A start arriving in the same cycle as done is ignored. A start arriving one cycle after done is accepted.

## Test plan
- Clean fill/check, SRAM model with L=1: base 0, N=4, seed 32'hA5A5_0000. Required: writes to addresses 0..3 with data A5A50000..A5A50003, four reads, done in cycle 10, err_count=0, first_err_addr=0.
- Fault injection: the model corrupts readdata at address 5 and address 9, with base 0, N=16. Required: err_count=2, first_err_addr=5.
- Wrap-around: base 14'h3FFE, N=4. Required: the address sequence 3FFE, 3FFF, 0000, 0001 in both the WRITE and READ phases.
- Zero count and busy start: a start with N=0 gives a done pulse in cycle 1, no chipselect, and err_count cleared. A second start pulse issued mid-test with N=8 leaves the address sequence and done timing unchanged.
- Reset mid-test: assert reset_n low during the READ phase. Required: all outputs return to their reset values in the same cycle, no done pulse, and a subsequent start runs normally.
- Latency sweep: READ_LATENCY=3 with N=8. Required: done in cycle 20, err_count=0, and compares aligned with the delayed readdata.
